// File: rtl/imm_extender.sv
// imm_extender: RV32I decode-stage immediate generator with one registered stage.
// Optional build macro IMM_SHAMT_EN: zero-extended 5-bit shamt for SLLI/SRLI/SRAI.
`default_nettype none

module imm_extender #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      imm_fmt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic [6:0]  opcode;
  logic        sign;
  logic [2:0]  fmt_next;
  logic [31:0] imm_next;

  assign opcode = instr[6:0];
  assign sign   = instr[31];

  always_comb begin
    fmt_next = FMT_NONE;
    unique case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011: fmt_next = FMT_I;
      7'b0100011:             fmt_next = FMT_S;
      7'b1100011:             fmt_next = FMT_B;
      7'b0110111, 7'b0010111: fmt_next = FMT_U;
      7'b1101111:             fmt_next = FMT_J;
      default:                fmt_next = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_next = 32'h0;
    case (fmt_next)
      FMT_I: imm_next = {{20{sign}}, instr[31:20]};
      FMT_S: imm_next = {{20{sign}}, instr[31:25], instr[11:7]};
      FMT_B: imm_next = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm_next = {instr[31:12], 12'h000};
      FMT_J: imm_next = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_next = 32'h0;
    endcase
`ifdef IMM_SHAMT_EN
    // Shift-immediates carry only the shamt; funct7 (incl. the SRAI bit) is dropped.
    if (opcode == 7'b0010011 && instr[13:12] == 2'b01)
      imm_next = {27'h0, instr[24:20]};
`endif
  end

  // Async reset dominates, so unknown instr bits cannot reach the register in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate <= '0;
      imm_fmt   <= FMT_NONE;
    end else begin
      immediate <= imm_next;
      imm_fmt   <= fmt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_extender.sv
// tb_imm_extender: directed vector table, reset corner cases and random instructions vs. a reference model.
`default_nettype none

module tb_imm_extender;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] immediate;
  logic [2:0]  imm_fmt;

  int checks;
  int failures;

  imm_extender #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .immediate (immediate),
    .imm_fmt   (imm_fmt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in;
    logic [31:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
    checks++;
    if (immediate !== exp_imm || imm_fmt !== exp_fmt) begin
      failures++;
      $display("FAIL %s: got imm=%h fmt=%0d, expected imm=%h fmt=%0d",
               name, immediate, imm_fmt, exp_imm, exp_fmt);
    end
  endtask

  // Reference model: immediates computed as signed integer offsets from field weights.
  function automatic void model(input logic [31:0] in, output logic [31:0] imm, output logic [2:0] fmt);
    int v;
    logic [6:0] op;
    op  = in[6:0];
    v   = 0;
    fmt = 3'd0;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h0f || op == 7'h73) begin
      fmt = 3'd1;
      v = int'(in[31:20]);
      if (v >= 2048) v -= 4096;
`ifdef IMM_SHAMT_EN
      if (op == 7'h13 && (in[14:12] == 3'd1 || in[14:12] == 3'd5)) v = int'(in[24:20]);
`endif
    end else if (op == 7'h23) begin
      fmt = 3'd2;
      v = int'(in[31:25]) * 32 + int'(in[11:7]);
      if (v >= 2048) v -= 4096;
    end else if (op == 7'h63) begin
      fmt = 3'd3;
      v = int'(in[31]) * 4096 + int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end else if (op == 7'h37 || op == 7'h17) begin
      fmt = 3'd4;
      v = int'(in[31:12]) * 4096;
    end else if (op == 7'h6f) begin
      fmt = 3'd5;
      v = int'(in[31]) * (1 << 20) + int'(in[19:12]) * (1 << 12) + int'(in[20]) * 2048
        + int'(in[30:21]) * 2;
      if (v >= (1 << 20)) v -= (1 << 21);
    end
    imm = 32'(v);
  endfunction

  task automatic apply(input logic [31:0] v);
    @(negedge clk);
    instr = v;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  logic [6:0] ops[12];

  initial begin
    logic [31:0] m_imm;
    logic [2:0]  m_fmt;
    logic [31:0] r;
    checks   = 0;
    failures = 0;

    vecs[0] = '{32'hffdff0ef, 32'hfffffffc, 3'd5};
    vecs[1] = '{32'h02830283, 32'h00000028, 3'd1};
    vecs[2] = '{32'hfe9246e3, 32'hffffffec, 3'd3};
    vecs[3] = '{32'h00129023, 32'h00000000, 3'd2};
    vecs[4] = '{32'h00001117, 32'h00001000, 3'd4};
    vecs[5] = '{32'h002081b3, 32'h00000000, 3'd0};
`ifdef IMM_SHAMT_EN
    vecs[6] = '{32'h4030d093, 32'h00000003, 3'd1};
`else
    vecs[6] = '{32'h4030d093, 32'h00000403, 3'd1};
`endif
    vecs[7] = '{32'hfffff06c, 32'h00000000, 3'd0};  // J opcode with instr[1:0]=00

    ops = '{7'h03, 7'h13, 7'h67, 7'h0f, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h13};

    // Reset holds outputs at zero while clock runs and a J instruction is present
    rst_n = 1'b0;
    instr = 32'hffdff0ef;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 32'hfffffffc, 3'd5);

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].in);
      check($sformatf("vec%0d_%h", i, vecs[i].in), vecs[i].imm, vecs[i].fmt);
    end

    // Asynchronous reset mid-stream clears outputs before any clock edge
    apply(32'hfe9246e3);
    check("pre_async", 32'hffffffec, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'h0, 3'd0);
    @(negedge clk);
    instr = 32'h02830283;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_async", 32'h00000028, 3'd1);

    // Random instructions, most carrying a recognised opcode
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 11)];
      apply(r);
      model(r, m_imm, m_fmt);
      check($sformatf("rand%0d_%h", i, r), m_imm, m_fmt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
